// File: rtl/binned_mem_reader_pkg.sv
// Shared widths, address packing, count-bus slicing and the FIFO entry
// layout for the binned stub memory reader.
package binned_mem_reader_pkg;

  localparam int RAM_WIDTH = 14;
  localparam int NPAGES    = 4;
  localparam int NBINS     = 8;
  localparam int NENT_BITS = 4;
  localparam int PW        = $clog2(NPAGES);
  localparam int BW        = $clog2(NBINS);
  localparam int AW        = PW + BW + NENT_BITS;
  localparam int NENT_W    = NPAGES * NBINS * NENT_BITS;

  typedef struct packed {
    logic [RAM_WIDTH-1:0] data;
    logic [BW-1:0]        bin;
    logic                 last;
  } entry_t;

  function automatic logic [AW-1:0] pack_addr(input logic [PW-1:0] pg,
                                              input logic [BW-1:0] b,
                                              input logic [NENT_BITS-1:0] s);
    return {pg, b, s};
  endfunction

  function automatic logic [NENT_BITS-1:0] nent_slice(input logic [NENT_W-1:0] all,
                                                      input logic [PW-1:0] pg,
                                                      input logic [BW-1:0] b);
    return all[(int'(pg) * NBINS + int'(b)) * NENT_BITS +: NENT_BITS];
  endfunction

endpackage

// File: rtl/binned_mem_reader_if.sv
// Memory read port and tagged output stream of the binned memory reader.
interface binned_mem_reader_if;
  import binned_mem_reader_pkg::*;

  logic                 mem_enb;
  logic [AW-1:0]        mem_addrb;
  logic                 mem_regceb;
  logic                 mem_rstb;
  logic [RAM_WIDTH-1:0] mem_doutb;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [RAM_WIDTH-1:0] dout_data;
  logic [BW-1:0]        dout_bin;
  logic                 dout_last;

  modport master (
    output mem_enb, mem_addrb, mem_regceb, mem_rstb,
    input  mem_doutb,
    output dout_valid, dout_data, dout_bin, dout_last,
    input  dout_ready
  );

  modport slave (
    input  mem_enb, mem_addrb, mem_regceb, mem_rstb,
    output mem_doutb,
    input  dout_valid, dout_data, dout_bin, dout_last,
    output dout_ready
  );

endinterface

// File: rtl/binned_mem_reader_fifo.sv
// Small synchronous skid FIFO for tagged memory entries; storage is not
// reset, only pointers and occupancy.
module binned_mem_reader_fifo
  import binned_mem_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PTRW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_pop;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The reader's credit check must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/binned_mem_reader.sv
// Scans a bin range of one page of the binned stub memory, issuing one read
// per stored entry and streaming the tagged results through a skid FIFO.
module binned_mem_reader
  import binned_mem_reader_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PW-1:0]       page,
  input  logic [BW-1:0]       bin_first,
  input  logic [BW-1:0]       bin_last,
  input  logic [NENT_W-1:0]   nent_all,
  binned_mem_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LATENCY + 1);

  logic [1:0]           state;
  logic [PW-1:0]        page_r;
  logic [BW-1:0]        bin_r;
  logic [BW-1:0]        bin_end;
  logic [NENT_BITS-1:0] slot;
  logic [NENT_BITS-1:0] cnt [NBINS];
  logic [IW-1:0]        inflight;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;

  logic                  scan;
  logic                  cur_empty;
  logic                  credit;
  logic                  rd_en;
  logic                  slot_end;
  logic                  adv;
  logic                  rest_empty;
  logic                  past_end;
  logic [BW-1:0]         idx;
  logic                  rd_last;
  logic                  push;
  logic                  pop;
  entry_t                push_entry;
  entry_t                head;

  logic [RD_LATENCY-1:0] vld_p;
  logic [BW-1:0]         bin_p  [RD_LATENCY];
  logic                  last_p [RD_LATENCY];

  assign scan      = (state == SCAN);
  assign cur_empty = (cnt[bin_r] == '0);
  assign credit    = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign rd_en     = scan && !cur_empty && credit;
  assign slot_end  = (slot == cnt[bin_r] - 1'b1);
  assign adv       = scan && (cur_empty || (credit && slot_end));
  assign rd_last   = slot_end && rest_empty;

  // Look ahead over the snapshot: does any bin after the current one, up to
  // bin_end, still hold entries?
  always_comb begin
    rest_empty = 1'b1;
    past_end   = (bin_r == bin_end);
    idx        = '0;
    for (int k = 1; k < NBINS; k++) begin
      idx = bin_r + BW'(k);
      if (!past_end && (cnt[idx] != '0)) rest_empty = 1'b0;
      if (idx == bin_end) past_end = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      page_r  <= '0;
      bin_r   <= '0;
      bin_end <= '0;
      slot    <= '0;
      for (int b = 0; b < NBINS; b++) cnt[b] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            page_r  <= page;
            bin_r   <= bin_first;
            bin_end <= bin_last;
            slot    <= '0;
            for (int b = 0; b < NBINS; b++) cnt[b] <= nent_slice(nent_all, page, BW'(b));
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (adv) begin
            slot <= '0;
            if (bin_r == bin_end) state <= DRAIN;
            else                  bin_r <= bin_r + 1'b1;
          end else if (rd_en) begin
            slot <= slot + 1'b1;
          end
        end
        DRAIN: begin
          if ((inflight == '0) && fifo_empty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0..pN: read tags travel alongside the memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p    <= '0;
      inflight <= '0;
    end else begin
      vld_p[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      inflight <= inflight + IW'(rd_en) - IW'(push);
    end
  end

  always_ff @(posedge clk) begin
    bin_p[0]  <= bin_r;
    last_p[0] <= rd_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      bin_p[i]  <= bin_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  // Pipe exit: memory data joins its tag and enters the skid FIFO
  assign push            = vld_p[RD_LATENCY-1];
  assign push_entry.data = bus.mem_doutb;
  assign push_entry.bin  = bin_p[RD_LATENCY-1];
  assign push_entry.last = last_p[RD_LATENCY-1];
  assign pop             = !fifo_empty && bus.dout_ready;

  binned_mem_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.mem_enb    = rd_en;
  assign bus.mem_addrb  = rd_en ? pack_addr(page_r, bin_r, slot) : '0;
  assign bus.mem_regceb = 1'b1;
  assign bus.mem_rstb   = rst;
  assign bus.dout_valid = !fifo_empty;
  assign bus.dout_data  = fifo_empty ? '0 : head.data;
  assign bus.dout_bin   = fifo_empty ? '0 : head.bin;
  assign bus.dout_last  = fifo_empty ? 1'b0 : head.last;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_binned_mem_reader.sv
// Directed table-driven bench for binned_mem_reader with a 2-cycle BRAM model.
module tb_binned_mem_reader;
  import binned_mem_reader_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [PW-1:0]     page;
  logic [BW-1:0]     bin_first;
  logic [BW-1:0]     bin_last;
  logic [NENT_W-1:0] nent_all;
  logic              busy;
  logic              done;

  binned_mem_reader_if bus();

  binned_mem_reader #(.RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .page      (page),
    .bin_first (bin_first),
    .bin_last  (bin_last),
    .nent_all  (nent_all),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RAM_WIDTH-1:0] mem_word(input logic [AW-1:0] a);
    return {5'b10110, a};
  endfunction

  // Output-registered BRAM: address at edge 1, output register at edge 2
  logic [RAM_WIDTH-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_enb) rd_q <= mem_word(bus.mem_addrb);
    bus.mem_doutb <= rd_q;
  end

  typedef struct packed {
    logic [RAM_WIDTH-1:0] d;
    logic [BW-1:0]        b;
    logic                 l;
  } beat_t;

  logic [AW-1:0] addr_q [$];
  beat_t         beat_q [$];
  int            issued = 0;
  int            popped = 0;
  int            done_total = 0;
  logic          stall_prev = 1'b0;
  beat_t         prev_beat;

  always @(negedge clk) begin
    if (rst) begin
      issued     = 0;
      popped     = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 32'(bus.dout_valid), 32'd1);
        check("stall_beat_stable", 32'({bus.dout_data, bus.dout_bin, bus.dout_last}), 32'(prev_beat));
      end
      if (bus.mem_enb) begin
        addr_q.push_back(bus.mem_addrb);
        issued++;
        check("outstanding_le_depth", 32'(issued - popped <= 4), 32'd1);
      end
      if (done) done_total++;
      if (bus.dout_valid && bus.dout_ready) begin
        beat_q.push_back({bus.dout_data, bus.dout_bin, bus.dout_last});
        popped++;
      end
      stall_prev = bus.dout_valid && !bus.dout_ready;
      prev_beat  = {bus.dout_data, bus.dout_bin, bus.dout_last};
    end
  end

  typedef struct {
    logic [PW-1:0]        pg;
    logic [BW-1:0]        bf;
    logic [BW-1:0]        bl;
    logic [31:0]          cnts;
    int                   rmode;
    int                   perturb;
    int                   n;
    int                   dcyc;
    logic [15:0][AW-1:0]  addr;
  } vec_t;

  vec_t vec [7];

  task automatic set_vec(input int i, input logic [PW-1:0] pg, input logic [BW-1:0] bf,
                         input logic [BW-1:0] bl, input logic [31:0] cnts,
                         input int rmode, input int perturb, input int n, input int dcyc);
    vec[i].pg = pg; vec[i].bf = bf; vec[i].bl = bl; vec[i].cnts = cnts;
    vec[i].rmode = rmode; vec[i].perturb = perturb; vec[i].n = n; vec[i].dcyc = dcyc;
    vec[i].addr = '0;
  endtask

  task automatic load_counts(input logic [PW-1:0] pg, input logic [31:0] cnts);
    nent_all = {NPAGES{32'h1111_1111}};
    nent_all[int'(pg)*32 +: 32] = cnts;
  endtask

  task automatic run_vec(input int vi);
    int a0, b0, d0, cyc, done_cyc;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] got_a;
    beat_t got_b;
    a0 = addr_q.size(); b0 = beat_q.size(); d0 = done_total;
    load_counts(vec[vi].pg, vec[vi].cnts);
    page = vec[vi].pg; bin_first = vec[vi].bf; bin_last = vec[vi].bl;
    bus.dout_ready = 1'b1;
    start = 1'b1;
    cyc = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (vec[vi].perturb != 0 && cyc == 3) begin
        nent_all = ~nent_all; page = 2'd3; bin_first = 3'd5; start = 1'b1;
      end
      bus.dout_ready = (vec[vi].rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (done) done_cyc = cyc;
    end
    check($sformatf("v%0d_no_timeout", vi), 32'(done_cyc != 0), 32'd1);
    bus.dout_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("v%0d_read_count", vi), 32'(addr_q.size() - a0), 32'(vec[vi].n));
    check($sformatf("v%0d_beat_count", vi), 32'(beat_q.size() - b0), 32'(vec[vi].n));
    for (int i = 0; i < vec[vi].n; i++) begin
      exp_a = vec[vi].addr[i];
      got_a = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : '1;
      got_b = (b0 + i < beat_q.size()) ? beat_q[b0 + i] : '1;
      check($sformatf("v%0d_addr%0d", vi, i), 32'(got_a), 32'(exp_a));
      check($sformatf("v%0d_data%0d", vi, i), 32'(got_b.d), 32'(mem_word(exp_a)));
      check($sformatf("v%0d_bin%0d", vi, i), 32'(got_b.b), 32'(exp_a[6:4]));
      check($sformatf("v%0d_last%0d", vi, i), 32'(got_b.l), 32'(i == vec[vi].n - 1));
    end
    check($sformatf("v%0d_done_pulses", vi), 32'(done_total - d0), 32'd1);
    check($sformatf("v%0d_idle_busy", vi), 32'(busy), 32'd0);
    if (vec[vi].dcyc != 0)
      check($sformatf("v%0d_done_cycle", vi), 32'(done_cyc), 32'(vec[vi].dcyc));
  endtask

  task automatic check_outputs_cleared(input string tag);
    check({tag, "_mem_enb"},    32'(bus.mem_enb), 32'd0);
    check({tag, "_mem_addrb"},  32'(bus.mem_addrb), 32'd0);
    check({tag, "_mem_regceb"}, 32'(bus.mem_regceb), 32'd1);
    check({tag, "_mem_rstb"},   32'(bus.mem_rstb), 32'd1);
    check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_dout_data"},  32'(bus.dout_data), 32'd0);
    check({tag, "_dout_bin"},   32'(bus.dout_bin), 32'd0);
    check({tag, "_dout_last"},  32'(bus.dout_last), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; page = '0; bin_first = '0; bin_last = '0;
    nent_all = '0; bus.dout_ready = 1'b0;

    set_vec(0, 2'd1, 3'd0, 3'd7, 32'h3000_1002, 0, 0, 6, 0);
    vec[0].addr[0] = 9'h080; vec[0].addr[1] = 9'h081; vec[0].addr[2] = 9'h0B0;
    vec[0].addr[3] = 9'h0F0; vec[0].addr[4] = 9'h0F1; vec[0].addr[5] = 9'h0F2;
    set_vec(1, 2'd2, 3'd6, 3'd1, 32'h0100_0002, 0, 0, 3, 0);
    vec[1].addr[0] = 9'h160; vec[1].addr[1] = 9'h100; vec[1].addr[2] = 9'h101;
    set_vec(2, 2'd0, 3'd4, 3'd4, 32'h000F_0000, 1, 0, 15, 0);
    for (int i = 0; i < 15; i++) vec[2].addr[i] = 9'h040 + 9'(i);
    set_vec(3, 2'd3, 3'd2, 3'd2, 32'h0000_2150, 0, 0, 1, 0);
    vec[3].addr[0] = 9'h1A0;
    set_vec(4, 2'd1, 3'd3, 3'd5, 32'h0402_0000, 0, 0, 2, 0);
    vec[4].addr[0] = 9'h0C0; vec[4].addr[1] = 9'h0C1;
    set_vec(5, 2'd0, 3'd0, 3'd7, 32'h0000_0000, 0, 0, 0, 10);
    set_vec(6, 2'd1, 3'd0, 3'd7, 32'h3000_1002, 0, 1, 6, 0);
    vec[6].addr = vec[0].addr;

    #1 rst = 1'b1;
    #1 check_outputs_cleared("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rstb_released", 32'(bus.mem_rstb), 32'd0);
    bus.dout_ready = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Mid-scan reset with three entries parked in the FIFO
    load_counts(2'd0, 32'h000F_0000);
    page = 2'd0; bin_first = 3'd4; bin_last = 3'd4;
    bus.dout_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(bus.dout_valid), 32'd1);
    check("pre_reset_head", 32'(bus.dout_data), 32'(mem_word(9'h040)));
    check("pre_reset_busy", 32'(busy), 32'd1);
    d0 = done_total;
    rst = 1'b1;
    #1 check_outputs_cleared("midscan_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(done_total - d0), 32'd0);
    check("idle_after_abort", 32'(busy), 32'd0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binned_mem_reader.md
Name: binned_mem_reader

Overview:
- Read-side sequencer for the 4-page x 8-bin x 16-slot binned stub memory.
- On a start command it snapshots the per-bin entry counts of one page and walks a bin range, skipping empty bins.
- It issues one memory read per stored entry, absorbs the fixed BRAM read latency, and presents the entries as a valid/ready stream tagged with bin number and end-of-scan.
- It sits between the binned memory and the consuming processing stage (e.g. match/tracklet engine).

Parameters:
RAM_WIDTH, 14, width of the memory data word and of dout_data
NPAGES, 4, number of pages; page field width PW = clog2(NPAGES) = 2
NBINS, 8, bins per page; bin field width BW = clog2(NBINS) = 3
NENT_BITS, 4, width of each entry count and of the slot index; slots per bin = 2^NENT_BITS
RD_LATENCY, 2, memory read latency in cycles: 2 for the output-registered memory, 1 for the low-latency memory
FIFO_DEPTH, 4, output skid FIFO depth; must be >= RD_LATENCY+2

Ports:
clk  in  1  single clock (memory clka/clkb both driven from it)
rst  in  1  reset, asynchronous, active-high
start  in  1  scan request, accepted only when busy=0
page  in  PW  page to scan, sampled with an accepted start
bin_first  in  BW  first bin of the scan, sampled with start
bin_last  in  BW  last bin of the scan (inclusive), sampled with start
nent_all  in  NPAGES*NBINS*NENT_BITS  all entry counts; page p, bin b at bits [(p*NBINS+b)*NENT_BITS +: NENT_BITS]
mem_enb  out  1  memory read enable
mem_addrb  out  PW+BW+NENT_BITS  memory read address {page, bin, slot}
mem_regceb  out  1  memory output register enable, constant 1
mem_rstb  out  1  memory output reset, equals rst
mem_doutb  in  RAM_WIDTH  memory read data
dout_valid  out  1  stream valid
dout_ready  in  1  stream ready
dout_data  out  RAM_WIDTH  entry data
dout_bin  out  BW  bin of the entry
dout_last  out  1  final entry of this scan
busy  out  1  scan in progress (start through done)
done  out  1  one-cycle pulse when the scan has completed and fully drained

Behaviour:
- Reset state: every output 0 except mem_regceb=1 and mem_rstb=rst. FSM in IDLE; FIFO, in-flight pipe and counters cleared. Reset mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1: latch page; latch bin=bin_first, bin_end=bin_last; snapshot the 8 counts of that page into cnt[]; set slot=0, busy=1; go to SCAN.
  - start while busy=1 is ignored.
- SCAN, one decision per cycle:
  - If cnt[bin]==0: no read; advance the bin.
  - Else, if credit is available: mem_enb=1, mem_addrb={page,bin,slot}. If slot==cnt[bin]-1, advance the bin with slot=0; otherwise slot++.
  - Else (no credit): hold; no read, no advance.
  - Credit rule: fifo_count + inflight < FIFO_DEPTH, evaluated on registered counts. A same-cycle pop is not counted.
  - Bin advance: if bin==bin_end, go to DRAIN; else bin = bin+1 mod NBINS. bin_last < bin_first wraps (e.g. 6,7,0,1); bin_first==bin_last scans one bin.
- Read tagging:
  - Each read carries {bin, last} through an RD_LATENCY-deep valid shift register.
  - last=1 when the read is the final slot of bin_end, or the final nonzero read before the range ends. This is computed by a look-ahead on the snapshot: no nonzero cnt in the remaining bins.
  - When a tag exits the pipe, {mem_doutb, bin, last} is pushed into the FIFO. The credit rule guarantees a push never meets a full FIFO; overflow is an assertion failure.
- Stream output:
  - dout_* is driven from the FIFO head; dout_valid = FIFO non-empty.
  - A pop occurs on dout_valid & dout_ready. Push and pop in the same cycle are legal.
  - dout_* stays stable while valid=1 and ready=0.
- DRAIN: wait until inflight==0 and FIFO empty, then go to DONE.
- DONE: done=1 for one cycle; busy=0 from the next cycle; return to IDLE. start during DONE is ignored.
- All bins empty: no reads and no stream beats; done arrives after (range length + 2) cycles.
- Snapshot isolation: nent_all changes after start do not affect the running scan.
- Throughput: with dout_ready held at 1, one read per cycle is sustained; latency from start to the first dout_valid is 1+RD_LATENCY cycles (first bin non-empty).

Decomposition:
- Shared package: address-field widths PW/BW/NENT_BITS, the address-pack function {page,bin,slot}, the nent bus slice function, and FIFO entry struct {data, bin, last}.
- One natural sub-module: binned_mem_reader_fifo, a small synchronous FIFO (depth FIFO_DEPTH, count output, async-reset) holding the tagged entries.

Test Plan:
- Page 1, bins 0..7, counts {2,0,0,1,0,0,0,3}, ready=1 -> addresses 0x080,0x081,0x0B0,0x0F0,0x0F1,0x0F2. Six beats with bins 0,0,3,7,7,7; last only on the sixth; one done pulse.
- Page 2, bins 6..1 (wrap), counts bin6=1, bin0=2, others 0 -> addresses 0x160,0x100,0x101; bins 6,0,0; last on the third beat.
- Page 0, bin 4 with count 15, ready toggling 1-0-0-1 -> all 15 beats in slot order; FIFO never exceeds 4; in-flight reads never exceed credit; data stable while stalled.
- All counts 0, bins 0..7 -> mem_enb stays 0, no beats, done pulse 10 cycles after start.
- Scan in progress; change nent_all and pulse start again -> output identical to the original snapshot; the second start is ignored.
- Assert rst mid-scan with the FIFO holding 3 entries -> all outputs 0 immediately (async), no done pulse. A new start after release runs correctly.
